credit_flowcontrol: RTL and testbench
=====================================

# credit_flowcontrol

Parametrised, credit-based flow control between a router's input stage and its per-direction output FIFOs (or downstream router buffers). Each output port keeps a registered credit counter, initialised to the downstream buffer depth. The counter is decremented on every flit sent and incremented on every credit returned. `ready_out` for a port is raised only when that port is selected and at least one credit remains. Sticky error flags record protocol violations, and live credit counts are exported for the arbiter and for debug.

## Interface
- `NUM_PORTS`, default 5: number of output directions; index order is L=0, N=1, E=2, W=3, S=4.
- `BUF_DEPTH`, default 4: downstream buffer depth in flits, and the initial credit count per port; legal range 1..255.
- `CNT_W`, default `$clog2(BUF_DEPTH+1)`: width of each credit counter.

- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `port_sel`, in, NUM_PORTS: one-hot (or zero) output direction requested by the routing logic.
- `send_valid`, in, NUM_PORTS: a flit is transferred to port p in this cycle.
- `credit_in`, in, NUM_PORTS: one credit is returned by downstream port p in this cycle.
- `ready_out`, out, NUM_PORTS: port p may accept a flit in this cycle; drives the arbiter and the previous router.
- `credit_cnt`, out, NUM_PORTS*CNT_W: flattened credit counters; port p occupies bits [p*CNT_W +: CNT_W].
- `err_underflow`, out, NUM_PORTS: sticky flag; a send was attempted with zero credits.
- `err_overflow`, out, NUM_PORTS: sticky flag; a credit was returned while the counter was already at BUF_DEPTH.

## Operation
- **Reset (asynchronous):** every `cnt[p]` = BUF_DEPTH, all error flags = 0, and `ready_out` = 0 while `rst` is high.
- **Ready logic (combinational from registered state):** `ready_out[p]` = !rst && `port_sel[p]` && (`cnt[p]` != 0).
- **Per-port counter update on each clock edge.** Let dec = `send_valid[p]` && (`cnt[p]` != 0) and inc = `credit_in[p]`.
  - dec && !inc: cnt - 1.
  - inc && !dec: cnt + 1, unless cnt == BUF_DEPTH. In that case cnt holds and `err_overflow[p]` is set.
  - inc && dec: cnt unchanged; this is legal even at 0 or at BUF_DEPTH.
  - Neither: hold.
- **Send with zero credits:** `send_valid[p]` while `cnt[p]` == 0 and no `credit_in[p]` in the same cycle sets `err_underflow[p]`. The counter stays at 0 and never wraps.
- **Send with zero credits plus same-cycle credit:** `send_valid[p]` while cnt == 0 together with `credit_in[p]` is treated as inc && dec. No error is flagged and cnt stays 0.
- **Independence of `send_valid` and `port_sel`:** `send_valid` is not qualified by `port_sel`. The counter tracks the actual transfers.
- **Ports are independent:** several ports may send or receive credits in the same cycle.
- **Error flags:** they clear only on `rst`.
- **Arithmetic:** counters are unsigned CNT_W bits and are never allowed to exceed BUF_DEPTH or go below 0.

## Timing
- **`ready_out` latency:**
  - Zero cycles from `port_sel`.
  - One cycle from a `send_valid` or `credit_in` that changes the counter.
- **Last credit:** after the send that consumes the last credit, `ready_out[p]` drops in the following cycle.
- **Credit return:** a credit returned at edge k makes `ready_out[p]` high from cycle k+1, provided `port_sel[p]` = 1.
- **`credit_cnt`:** reflects the registered value and is updated one edge after the event.
- **Reset mid-transfer:** any in-flight `send_valid` or `credit_in` is discarded. Counters return to BUF_DEPTH immediately and asynchronously, not waiting for a clock edge.
- **First cycle after reset:** the first active edge after `rst` falls performs normal updates.

## Test plan
1. **Reset values.** Assert `rst` mid-cycle, then release it. Expect:
   - all `credit_cnt` fields = 4 and all error flags = 0;
   - `ready_out` = 0 during reset;
   - with `port_sel` = 5'b00010 after release, `ready_out` = 5'b00010.
2. **Drain to zero.** Hold `port_sel[E]` = 1 and `send_valid[E]` = 1 for 4 cycles. Expect cnt[E] 4→3→2→1→0 and `ready_out[E]` = 0 from cycle 5. A 5th send sets `err_underflow[E]` = 1 and cnt stays 0.
3. **Simultaneous send and credit.** At cnt[N] = 0, pulse `send_valid[N]` and `credit_in[N]` together. Expect cnt stays 0 and no error. One `credit_in[N]` pulse then gives cnt = 1 and `ready_out[N]` = 1.
4. **Credit overflow.** At cnt[S] = 4, pulse `credit_in[S]`. Expect cnt stays 4 and `err_overflow[S]` = 1, staying set until `rst`.
5. **Port independence.** Send on L and W each cycle while returning credits on W only. Expect cnt[L] to reach 0 after 4 cycles while cnt[W] holds at 4. Other ports are unaffected.
6. **Parameter sweep.** Run scenarios 2–4 with NUM_PORTS = 8 and BUF_DEPTH = 16 (CNT_W = 5). Expect drain takes 16 sends and no counter exceeds 16.

Source files
------------

// File: rtl/credit_flowcontrol_if.sv
// Router-side handshake bundle for credit-based output flow control.
// The master drives selection, transfers and returned credits; the slave reports readiness, counts and errors.
interface credit_flowcontrol_if #(
  parameter int NUM_PORTS = 5,
  parameter int CNT_W     = 3
);
  logic [NUM_PORTS-1:0]       port_sel;
  logic [NUM_PORTS-1:0]       send_valid;
  logic [NUM_PORTS-1:0]       credit_in;
  logic [NUM_PORTS-1:0]       ready_out;
  logic [NUM_PORTS*CNT_W-1:0] credit_cnt;
  logic [NUM_PORTS-1:0]       err_underflow;
  logic [NUM_PORTS-1:0]       err_overflow;

  modport master (
    output port_sel, send_valid, credit_in,
    input  ready_out, credit_cnt, err_underflow, err_overflow
  );

  modport slave (
    input  port_sel, send_valid, credit_in,
    output ready_out, credit_cnt, err_underflow, err_overflow
  );
endinterface

// File: rtl/credit_flowcontrol.sv
// Per-port credit counters between router input stage and downstream buffers, with sticky error flags.
// ready_out is combinational from port_sel and registered counts; counts update one edge after send/credit.
module credit_flowcontrol #(
  parameter int NUM_PORTS = 5,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  credit_flowcontrol_if.slave fc
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0]     cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] uf_q;
  logic [NUM_PORTS-1:0] of_q;

  // A send and a credit in the same cycle cancel, even at empty or full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) cnt[p] <= FULL;
      uf_q <= '0;
      of_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (fc.send_valid[p] && !fc.credit_in[p]) begin
          if (cnt[p] == '0) uf_q[p] <= 1'b1;
          else              cnt[p]  <= cnt[p] - ONE;
        end else if (fc.credit_in[p] && !fc.send_valid[p]) begin
          if (cnt[p] == FULL) of_q[p] <= 1'b1;
          else                cnt[p]  <= cnt[p] + ONE;
        end
      end
    end
  end

  always_comb begin
    fc.ready_out  = '0;
    fc.credit_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      fc.ready_out[p]                  = !rst && fc.port_sel[p] && (cnt[p] != '0);
      fc.credit_cnt[p*CNT_W +: CNT_W]  = cnt[p];
    end
  end

  assign fc.err_underflow = uf_q;
  assign fc.err_overflow  = of_q;
endmodule

// File: tb/tb_credit_flowcontrol.sv
// Drives a default (5 ports, depth 4) and a wide (8 ports, depth 16) instance with the same stimulus
// and compares both against a per-port behavioural credit model.
module tb_credit_flowcontrol;
  logic clk;
  logic rst;

  credit_flowcontrol_if #(.NUM_PORTS(5), .CNT_W(3)) ifa ();
  credit_flowcontrol_if #(.NUM_PORTS(8), .CNT_W(5)) ifb ();

  credit_flowcontrol #(.NUM_PORTS(5), .BUF_DEPTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .fc  (ifa.slave)
  );

  credit_flowcontrol #(.NUM_PORTS(8), .BUF_DEPTH(16), .CNT_W(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .fc  (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: credits held per port, plus sticky flags
  int       ma [5];
  int       mb [8];
  bit [7:0] ufa, ofa, ufb, ofb;
  logic [7:0] cur_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void mstep(inout int c, inout bit uf, inout bit of,
                                input bit s, input bit cr, input int depth);
    if (s && cr) return;
    if (s) begin
      if (c == 0) uf = 1'b1;
      else        c  = c - 1;
    end else if (cr) begin
      if (c == depth) of = 1'b1;
      else            c  = c + 1;
    end
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 5; p++) ma[p] = 4;
    for (int p = 0; p < 8; p++) mb[p] = 16;
    ufa = '0; ofa = '0; ufb = '0; ofb = '0;
  endtask

  task automatic check_state(input string ph);
    logic [63:0] ea, eb;
    ea = '0; eb = '0;
    for (int p = 0; p < 5; p++) ea[p*3 +: 3] = 3'(ma[p]);
    for (int p = 0; p < 8; p++) eb[p*5 +: 5] = 5'(mb[p]);
    chk({ph, " cnt_a"}, 64'(ifa.credit_cnt), ea);
    chk({ph, " cnt_b"}, 64'(ifb.credit_cnt), eb);
    chk({ph, " uf_a"},  64'(ifa.err_underflow), 64'(ufa[4:0]));
    chk({ph, " of_a"},  64'(ifa.err_overflow),  64'(ofa[4:0]));
    chk({ph, " uf_b"},  64'(ifb.err_underflow), 64'(ufb));
    chk({ph, " of_b"},  64'(ifb.err_overflow),  64'(ofb));
  endtask

  task automatic check_ready(input string ph);
    logic [7:0] ra, rb;
    ra = '0; rb = '0;
    for (int p = 0; p < 5; p++) ra[p] = !rst && cur_sel[p] && (ma[p] != 0);
    for (int p = 0; p < 8; p++) rb[p] = !rst && cur_sel[p] && (mb[p] != 0);
    chk({ph, " rdy_a"}, 64'(ifa.ready_out), 64'(ra[4:0]));
    chk({ph, " rdy_b"}, 64'(ifb.ready_out), 64'(rb));
  endtask

  task automatic drive(input logic [7:0] sel, input logic [7:0] send, input logic [7:0] cred);
    cur_sel = sel;
    ifa.port_sel = sel[4:0]; ifa.send_valid = send[4:0]; ifa.credit_in = cred[4:0];
    ifb.port_sel = sel;      ifb.send_valid = send;      ifb.credit_in = cred;
  endtask

  // entered just after a falling edge; leaves at the next falling edge
  task automatic step(input string ph, input logic [7:0] sel, input logic [7:0] send, input logic [7:0] cred);
    drive(sel, send, cred);
    #1 check_ready(ph);
    @(posedge clk);
    for (int p = 0; p < 5; p++) mstep(ma[p], ufa[p], ofa[p], send[p], cred[p], 4);
    for (int p = 0; p < 8; p++) mstep(mb[p], ufb[p], ofb[p], send[p], cred[p], 16);
    #1 check_state(ph);
    @(negedge clk);
  endtask

  // asynchronous reset asserted mid-cycle with traffic still applied
  task automatic do_reset(input string ph);
    drive(8'hFF, 8'hFF, 8'h0F);
    #2 rst = 1'b1;
    model_reset();
    #1 check_state({ph, " async"});
    check_ready({ph, " async"});
    @(posedge clk);
    #1 check_state({ph, " held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'hFF, 8'h00, 8'h00);
    model_reset();
    #3 check_state("reset");
    check_ready("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: selection alone gives ready with zero latency
    step("sel_n", 8'h02, 8'h00, 8'h00);

    // 2: drain E; fifth send is an underflow on the small instance
    for (int i = 0; i < 5; i++) step("drain_e", 8'h04, 8'h04, 8'h00);
    // keep draining the wide instance to empty and past it
    for (int i = 0; i < 12; i++) step("drain_e16", 8'h04, 8'h04, 8'h00);
    step("idle_e", 8'h04, 8'h00, 8'h00);

    // 3: empty N, then send+credit together, then a lone credit
    for (int i = 0; i < 16; i++) step("drain_n", 8'h02, 8'h02, 8'h00);
    step("sc_n", 8'h02, 8'h02, 8'h02);
    step("cr_n", 8'h02, 8'h00, 8'h02);
    step("rdy_n", 8'h02, 8'h00, 8'h00);

    // 4: credit on a full S counter; flag stays sticky afterwards
    step("ovf_s", 8'h10, 8'h00, 8'h10);
    step("send_s", 8'h10, 8'h10, 8'h00);
    step("sticky_s", 8'h10, 8'h00, 8'h00);

    // 5: L and W both send, only W gets credits back
    for (int i = 0; i < 4; i++) step("indep", 8'h01, 8'h09, 8'h08);
    step("indep_w", 8'h08, 8'h00, 8'h00);

    do_reset("rst1");
    step("post_rst", 8'h02, 8'h02, 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] sel, send, cred;
      sel  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      send = 8'($urandom) | 8'($urandom);
      cred = 8'($urandom) & 8'($urandom);
      if (i == 200) do_reset("rst_rand");
      step("rand", sel, send, cred);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
